vsync_monitor: RTL
==================

# vsync_monitor

Receive-side counterpart to the VGA vertical sync generator: samples incoming `vsync_in`/`hsync_in`, measures frame period and sync-pulse width in `clk` cycles, and declares lock after consecutive in-tolerance frames. Once locked, recovers the row address `vaddr` by counting hsync pulses in the active region and dividing by `ROW_DIV`. Sits at the capture end of a VGA link, feeding row-addressed logic and a lock indicator.

## Interface
- `FRAME_CYCLES`, 833600: nominal vsync period in clk cycles.
- `VSYNC_CYCLES`, 3200: nominal vsync low-pulse width.
- `TOL`, 16: allowed ± deviation for period and pulse width, inclusive.
- `LOCK_FRAMES`, 3: consecutive good frames required for lock.
- `FIRST_ACTIVE`, 31: line index of the first active line; line 0 starts at the vsync falling edge.
- `ACTIVE_LINES`, 480: number of active lines.
- `ROW_DIV`, 6: lines per `vaddr` step.
- `CNT_W`, 20: cycle counter width.

Ports:
- `clk` input 1: system clock.
- `reset` input 1: asynchronous, active-high reset.
- `vsync_in` input 1: asynchronous vsync, active low.
- `hsync_in` input 1: asynchronous hsync, active low.
- `locked` output 1: high in the LOCKED state.
- `v_active` output 1: high when `locked` and the current line is active.
- `vaddr` output 7: recovered row address.
- `frame_err` output 1: one-cycle pulse when a frame fails its check.
- `period_meas` output CNT_W: last measured frame period (see Configuration).

## Operation
- Each input passes through a 2-FF synchronizer, then a registered copy for edge detection. Vsync and hsync frame boundaries are the falling edges of the synchronized signals.
- `period_cnt` clears to 1 on a vsync falling edge and otherwise increments, saturating at all-ones.
- `low_cnt` counts cycles while synchronized vsync is low and clears on the falling edge.
- On the vsync rising edge, `pulse_ok` is latched as |low_cnt − VSYNC_CYCLES| ≤ TOL.
- On a vsync falling edge:
  - `frame_good` = `pulse_ok` AND |period_cnt − FRAME_CYCLES| ≤ TOL.
  - `period_meas` is loaded with `period_cnt`.
- The first falling edge after SEARCH carries no valid period and is never judged.
- FSM states: SEARCH, ACQUIRE, LOCKED.
  - SEARCH: on a vsync falling edge, go to ACQUIRE with `good_cnt` = 0.
  - ACQUIRE: on each falling edge, a good frame increments `good_cnt`. When it reaches LOCK_FRAMES, go to LOCKED. A bad frame pulses `frame_err`, clears `good_cnt`, and stays in ACQUIRE.
  - LOCKED: a bad frame pulses `frame_err` and goes to ACQUIRE with `good_cnt` = 0.
  - Timeout: in ACQUIRE or LOCKED, if `period_cnt` > FRAME_CYCLES+TOL, go to SEARCH. This catches a missing vsync.
- Line counter (9 bits):
  - Set to 0 on a vsync falling edge; otherwise increments on each hsync falling edge, saturating at 511.
  - If vsync and hsync falling edges occur in the same cycle, vsync wins and the line counter becomes 0.
- Active region: FIRST_ACTIVE ≤ line < FIRST_ACTIVE+ACTIVE_LINES.
- Row recovery:
  - On entry to the active region, `vaddr` and `div_cnt` are 0.
  - Each later hsync falling edge inside the region advances `div_cnt`. At ROW_DIV−1 it wraps to 0 and `vaddr` increments, saturating at 127.
  - Outside the region, `vaddr` holds its value until the next vsync falling edge clears it to 0.
  - With defaults, `vaddr` spans 0..79.

## Timing
- Reset values: `locked`=0, `v_active`=0, `vaddr`=0, `frame_err`=0, `period_meas`=0. State is SEARCH and all counters are 0. Synchronizer flops reset to 1 (idle high), so reset never creates a false edge.
- Latency: a pin transition reaches the synchronizer output 2 clk later. The edge is detected the following cycle and registered outputs update on the next edge, 3 clk from the pin in total.
- `locked` rises on the same clock that judges the LOCK_FRAMES-th good frame, and falls on the same clock as `frame_err` or timeout.
- `frame_err` is exactly 1 cycle wide.
- Reset mid-frame clears everything immediately. Reacquisition then needs 1 + LOCK_FRAMES vsync falling edges.
- The judged period equals the true period in clk cycles: `period_cnt` clears to 1 on the edge.

## Configuration
- `VSYNC_MON_PERIOD_REG_EN` defined: the `period_meas` register is implemented and updated as described.
- Not defined: the register is removed and `period_meas` is tied to 0. The port is kept so the interface is unchanged; lock behaviour is identical.

## Test plan
- Nominal 640x480 stream (period 833600, pulse 3200, line 1600) → `locked` rises at the 4th vsync falling edge; `vaddr` steps 0..79; `v_active` covers 480 lines per frame.
- Period 833617 (TOL+1) for one frame while locked → one `frame_err` pulse, `locked`=0, relock after 3 further good frames.
- Pulse width 3184 (−16, in tolerance) → frame accepted, no `frame_err`; width 3183 → rejected.
- vsync held high after lock → `locked` falls when `period_cnt` exceeds 833616; state is SEARCH.
- vsync and hsync falling edges in the same cycle → line counter = 0, no extra line counted; first active line still 31.
- `reset` asserted mid-active region with `vaddr`=40 → all outputs 0 immediately; with the macro defined, `period_meas`=833600 after relock.

Source files
------------

// File: rtl/vsync_monitor_if.sv
// Bus between a VGA sync source and vsync_monitor.
// The master drives the raw sync pins; the slave (the monitor) drives the status outputs.
interface vsync_monitor_if #(
  parameter int unsigned CNT_W = 20
) ();
  logic             vsync_in;
  logic             hsync_in;
  logic             locked;
  logic             v_active;
  logic [6:0]       vaddr;
  logic             frame_err;
  logic [CNT_W-1:0] period_meas;

  modport master (
    output vsync_in,
    output hsync_in,
    input  locked,
    input  v_active,
    input  vaddr,
    input  frame_err,
    input  period_meas
  );

  modport slave (
    input  vsync_in,
    input  hsync_in,
    output locked,
    output v_active,
    output vaddr,
    output frame_err,
    output period_meas
  );
endinterface

// File: rtl/vsync_monitor.sv
// VGA receive-side sync monitor: measures vsync period and pulse width, declares lock after
// LOCK_FRAMES consecutive good frames, and recovers the row address from hsync pulses.
// Optional macro VSYNC_MON_PERIOD_REG_EN: when defined, period_meas holds the last measured
// frame period; otherwise period_meas is tied to 0.
module vsync_monitor #(
  parameter int unsigned FRAME_CYCLES = 833600,
  parameter int unsigned VSYNC_CYCLES = 3200,
  parameter int unsigned TOL          = 16,
  parameter int unsigned LOCK_FRAMES  = 3,
  parameter int unsigned FIRST_ACTIVE = 31,
  parameter int unsigned ACTIVE_LINES = 480,
  parameter int unsigned ROW_DIV      = 6,
  parameter int unsigned CNT_W        = 20
) (
  input logic            clk,
  input logic            reset,
  vsync_monitor_if.slave bus
);

  typedef enum logic [1:0] {StSearch, StAcquire, StLocked} state_e;

  localparam int unsigned GoodW = $clog2(LOCK_FRAMES + 1);
  localparam int unsigned DivW  = (ROW_DIV > 1) ? $clog2(ROW_DIV) : 1;

  localparam logic [CNT_W-1:0] PeriodMin  = CNT_W'(FRAME_CYCLES - TOL);
  localparam logic [CNT_W-1:0] PeriodMax  = CNT_W'(FRAME_CYCLES + TOL);
  localparam logic [CNT_W-1:0] PulseMin   = CNT_W'(VSYNC_CYCLES - TOL);
  localparam logic [CNT_W-1:0] PulseMax   = CNT_W'(VSYNC_CYCLES + TOL);
  localparam logic [8:0]       LineFirst  = 9'(FIRST_ACTIVE);
  localparam logic [8:0]       LineEnd    = 9'(FIRST_ACTIVE + ACTIVE_LINES);
  localparam logic [GoodW-1:0] GoodLast   = GoodW'(LOCK_FRAMES - 1);
  localparam logic [GoodW-1:0] GoodTarget = GoodW'(LOCK_FRAMES);
  localparam logic [DivW-1:0]  DivLast    = DivW'(ROW_DIV - 1);

  logic vs_s1_q, vs_s2_q, vs_d_q;
  logic hs_s1_q, hs_s2_q, hs_d_q;
  logic vs_fall, vs_rise, hs_fall;

  logic [CNT_W-1:0] period_cnt_q, period_cnt_d;
  logic [CNT_W-1:0] low_cnt_q, low_cnt_d;
  logic             pulse_ok_q, pulse_ok_d;
  logic [8:0]       line_q, line_d;
  logic [DivW-1:0]  div_q, div_d;
  logic [6:0]       vaddr_q, vaddr_d;
  logic             act_q, act_d;
  logic             frame_good, timeout;

  state_e           state_q, state_d;
  logic [GoodW-1:0] good_cnt_q, good_cnt_d;
  logic             locked_q, locked_d;
  logic             frame_err_q, frame_err_d;
  logic             v_active_q, v_active_d;

  // 2-FF synchronizers plus edge-detect copy; idle-high reset so reset never fakes an edge.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vs_s1_q <= 1'b1;
      vs_s2_q <= 1'b1;
      vs_d_q  <= 1'b1;
      hs_s1_q <= 1'b1;
      hs_s2_q <= 1'b1;
      hs_d_q  <= 1'b1;
    end else begin
      vs_s1_q <= bus.vsync_in;
      vs_s2_q <= vs_s1_q;
      vs_d_q  <= vs_s2_q;
      hs_s1_q <= bus.hsync_in;
      hs_s2_q <= hs_s1_q;
      hs_d_q  <= hs_s2_q;
    end
  end

  assign vs_fall = vs_d_q & ~vs_s2_q;
  assign vs_rise = ~vs_d_q & vs_s2_q;
  assign hs_fall = hs_d_q & ~hs_s2_q;

  assign frame_good = pulse_ok_q && (period_cnt_q >= PeriodMin) && (period_cnt_q <= PeriodMax);
  assign timeout    = period_cnt_q > PeriodMax;

  // Period/pulse measurement and line/row recovery next-state.
  // Both cycle counters restart at 1 on the edge so they read true cycle counts when judged.
  always_comb begin
    period_cnt_d = period_cnt_q;
    low_cnt_d    = low_cnt_q;
    pulse_ok_d   = pulse_ok_q;
    line_d       = line_q;
    div_d        = div_q;
    vaddr_d      = vaddr_q;

    if (vs_fall) begin
      period_cnt_d = CNT_W'(1);
    end else if (!(&period_cnt_q)) begin
      period_cnt_d = period_cnt_q + CNT_W'(1);
    end

    if (vs_fall) begin
      low_cnt_d = CNT_W'(1);
    end else if (!vs_s2_q && !(&low_cnt_q)) begin
      low_cnt_d = low_cnt_q + CNT_W'(1);
    end

    // pulse_ok covers exactly one frame: set at the rise, consumed and cleared at the fall.
    if (vs_rise) begin
      pulse_ok_d = (low_cnt_q >= PulseMin) && (low_cnt_q <= PulseMax);
    end else if (vs_fall) begin
      pulse_ok_d = 1'b0;
    end

    // vsync wins over a coincident hsync edge.
    if (vs_fall) begin
      line_d = 9'd0;
    end else if (hs_fall && (line_q != 9'h1ff)) begin
      line_d = line_q + 9'd1;
    end

    act_d = (line_d >= LineFirst) && (line_d < LineEnd);

    if (vs_fall || (act_d && !act_q)) begin
      div_d   = '0;
      vaddr_d = 7'd0;
    end else if (act_d && act_q && hs_fall) begin
      if (div_q == DivLast) begin
        div_d = '0;
        if (vaddr_q != 7'h7f) vaddr_d = vaddr_q + 7'd1;
      end else begin
        div_d = div_q + DivW'(1);
      end
    end
  end

  assign act_q = (line_q >= LineFirst) && (line_q < LineEnd);

  // Lock FSM next-state; the first falling edge out of search is never judged.
  always_comb begin
    state_d     = state_q;
    good_cnt_d  = good_cnt_q;
    frame_err_d = 1'b0;
    unique case (state_q)
      StSearch: begin
        if (vs_fall) begin
          state_d    = StAcquire;
          good_cnt_d = '0;
        end
      end
      StAcquire: begin
        if (vs_fall) begin
          if (frame_good) begin
            if (good_cnt_q == GoodLast) begin
              state_d    = StLocked;
              good_cnt_d = GoodTarget;
            end else begin
              good_cnt_d = good_cnt_q + GoodW'(1);
            end
          end else begin
            frame_err_d = 1'b1;
            good_cnt_d  = '0;
          end
        end else if (timeout) begin
          state_d = StSearch;
        end
      end
      StLocked: begin
        if (vs_fall) begin
          if (!frame_good) begin
            frame_err_d = 1'b1;
            state_d     = StAcquire;
            good_cnt_d  = '0;
          end
        end else if (timeout) begin
          state_d = StSearch;
        end
      end
      default: state_d = StSearch;
    endcase
    locked_d   = state_d == StLocked;
    v_active_d = locked_d && act_d;
  end

  // State registers for counters, FSM and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      period_cnt_q <= '0;
      low_cnt_q    <= '0;
      pulse_ok_q   <= 1'b0;
      line_q       <= 9'd0;
      div_q        <= '0;
      vaddr_q      <= 7'd0;
      state_q      <= StSearch;
      good_cnt_q   <= '0;
      locked_q     <= 1'b0;
      frame_err_q  <= 1'b0;
      v_active_q   <= 1'b0;
    end else begin
      period_cnt_q <= period_cnt_d;
      low_cnt_q    <= low_cnt_d;
      pulse_ok_q   <= pulse_ok_d;
      line_q       <= line_d;
      div_q        <= div_d;
      vaddr_q      <= vaddr_d;
      state_q      <= state_d;
      good_cnt_q   <= good_cnt_d;
      locked_q     <= locked_d;
      frame_err_q  <= frame_err_d;
      v_active_q   <= v_active_d;
    end
  end

  assign bus.locked    = locked_q;
  assign bus.v_active  = v_active_q;
  assign bus.vaddr     = vaddr_q;
  assign bus.frame_err = frame_err_q;

`ifdef VSYNC_MON_PERIOD_REG_EN
  logic [CNT_W-1:0] period_meas_q, period_meas_d;

  // Capture the period of the frame that just ended.
  always_comb begin
    period_meas_d = period_meas_q;
    if (vs_fall) period_meas_d = period_cnt_q;
  end

  // Period measurement register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) period_meas_q <= '0;
    else       period_meas_q <= period_meas_d;
  end

  assign bus.period_meas = period_meas_q;
`else
  assign bus.period_meas = '0;
`endif

endmodule
